// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the multicycle controller and the datapath
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       alu_zero;
  logic       branch_neg;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       illegal_instr;
  logic       mem_fault;
  logic [3:0] state;

  modport slave (
    input  opcode, alu_zero, branch_neg, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, mem_fault, state
  );

  modport master (
    output opcode, alu_zero, branch_neg, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, mem_fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle main control FSM with memory stall watchdog
module multicycle_controller #(
  parameter int STALL_LIMIT = 0
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_controller_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam int             CW    = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [CW-1:0]  LIMIT = CW'(STALL_LIMIT);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;

  logic       w_wait;
  logic       w_fault;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_src;

  assign w_wait  = ((r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE))
                   && !bus.mem_ready;
  assign w_fault = (STALL_LIMIT > 0) && w_wait && (r_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter restarts whenever the access completes, the state moves, or the watchdog fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((STALL_LIMIT == 0) || w_fault || !w_wait || (w_next != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_pc_write  = ~(bus.alu_zero ^ bus.branch_neg);
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
    // An expired watchdog abandons the access without touching PC, IR or memory.
    if (w_fault) begin
      w_next      = S_FETCH;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
    end
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (bus.opcode)
      7'b0100011: w_imm_src = 2'b01;
      7'b1100011: w_imm_src = 2'b10;
      7'b1101111: w_imm_src = 2'b11;
      default:    w_imm_src = 2'b00;
    endcase
  end

  assign bus.pc_write      = w_pc_write  & ~rst;
  assign bus.ir_write      = w_ir_write  & ~rst;
  assign bus.mem_write     = w_mem_write & ~rst;
  assign bus.reg_write     = w_reg_write & ~rst;
  assign bus.illegal_instr = w_illegal   & ~rst;
  assign bus.mem_fault     = w_fault     & ~rst;
  assign bus.adr_src       = w_adr_src;
  assign bus.result_src    = w_result_src;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.imm_src       = w_imm_src;
  assign bus.state         = r_state;

endmodule
